esn_sram_addr_gen: RTL and testbench

- Address generator sitting directly downstream of the ESN control FSM.
- Consumes the FSM's 2-bit SRAM state code and its active-low address-update enables.
- Produces registered read addresses for the X, W, Win, Winb and Wout SRAMs, plus the input-sample address.
- Tracks point progress and flags end-of-sequence for the datapath and the FSM.

---
 rtl/esn_sram_addr_gen.sv | 147 ++++++++++++++
 tb/tb_esn_sram_addr_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esn_sram_addr_gen.sv
// esn_sram_addr_gen: registered SRAM read-address generator for the ESN datapath.
// It follows the control FSM's 2-bit SRAM state code and active-low enables,
// and produces the X/W/Win/Winb/Wout addresses plus the input-sample index.
// Optional macro ESN_ADDR_GEN_ERR_EN enables the sticky protocol-error flag
// addr_err; without it, addr_err is tied to 0.
//
// Enable semantics: an enable sampled low at a rising edge while SRAM_State is
// 2'b10 advances its address at that same edge (one-cycle latency to the
// output). Enables are level-sensitive, so holding one low advances once per cycle.
module esn_sram_addr_gen #(
  parameter int NODE_NUM  = 1000,
  parameter int POINT_NUM = 2000,
  parameter int AW_N      = 10,
  parameter int AW_W      = 20,
  parameter int AW_P      = 11
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [1:0]      SRAM_State,
  input  logic            EN_update_addr_X_n,
  input  logic            EN_update_addr_W_n,
  input  logic            EN_update_addr_Win_n,
  input  logic            EN_update_addr_Winb_n,
  input  logic            EN_update_addr_Wout_n,
  output logic [AW_N-1:0] addr_X,
  output logic [AW_W-1:0] addr_W,
  output logic [AW_N-1:0] addr_Win,
  output logic [AW_N-1:0] addr_Winb,
  output logic [AW_N-1:0] addr_Wout,
  output logic [AW_P-1:0] addr_u,
  output logic            x_wrap,
  output logic            seq_done,
  output logic            addr_err
);

  localparam logic [1:0]      ST_RUN = 2'b10;
  localparam logic [1:0]      ST_ILL = 2'b11;
  localparam logic [AW_N-1:0] N_LAST = AW_N'(NODE_NUM - 1);
  localparam logic [AW_P-1:0] P_LAST = AW_P'(POINT_NUM - 1);
  localparam logic [AW_N-1:0] N_ONE  = AW_N'(1);
  localparam logic [AW_P-1:0] P_ONE  = AW_P'(1);
  localparam logic [AW_W-1:0] W_ONE  = AW_W'(1);

  // Only the run state lets counters move; idle, preload and illegal all clear.
  logic run;
  assign run = (SRAM_State == ST_RUN);

  // W is walked as row/col so the wrap test never needs a multiply.
  logic [AW_N-1:0] w_row;
  logic [AW_N-1:0] w_col;

  // X address, point index and the wrap/done pulses.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_X   <= '0;
      addr_u   <= '0;
      x_wrap   <= 1'b0;
      seq_done <= 1'b0;
    end else if (!run) begin
      addr_X   <= '0;
      addr_u   <= '0;
      x_wrap   <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      x_wrap   <= 1'b0;
      seq_done <= 1'b0;
      if (!EN_update_addr_X_n) begin
        if (addr_X == N_LAST) begin
          addr_X <= '0;
          x_wrap <= 1'b1;
          if (addr_u == P_LAST) begin
            addr_u   <= '0;
            seq_done <= 1'b1;
          end else begin
            addr_u <= addr_u + P_ONE;
          end
        end else begin
          addr_X <= addr_X + N_ONE;
        end
      end
    end
  end

  // W address as a linear row*NODE_NUM+col counter, stepped by +1.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_W <= '0;
      w_row  <= '0;
      w_col  <= '0;
    end else if (!run) begin
      addr_W <= '0;
      w_row  <= '0;
      w_col  <= '0;
    end else if (!EN_update_addr_W_n) begin
      if (w_col != N_LAST) begin
        w_col  <= w_col + N_ONE;
        addr_W <= addr_W + W_ONE;
      end else if (w_row != N_LAST) begin
        w_col  <= '0;
        w_row  <= w_row + N_ONE;
        addr_W <= addr_W + W_ONE;
      end else begin
        w_col  <= '0;
        w_row  <= '0;
        addr_W <= '0;
      end
    end
  end

  // Win / Winb / Wout: independent modulo-NODE_NUM counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_Win  <= '0;
      addr_Winb <= '0;
      addr_Wout <= '0;
    end else if (!run) begin
      addr_Win  <= '0;
      addr_Winb <= '0;
      addr_Wout <= '0;
    end else begin
      if (!EN_update_addr_Win_n)
        addr_Win <= (addr_Win == N_LAST) ? '0 : addr_Win + N_ONE;
      if (!EN_update_addr_Winb_n)
        addr_Winb <= (addr_Winb == N_LAST) ? '0 : addr_Winb + N_ONE;
      if (!EN_update_addr_Wout_n)
        addr_Wout <= (addr_Wout == N_LAST) ? '0 : addr_Wout + N_ONE;
    end
  end

`ifdef ESN_ADDR_GEN_ERR_EN
  logic any_en;
  assign any_en = !EN_update_addr_X_n  || !EN_update_addr_W_n    ||
                  !EN_update_addr_Win_n || !EN_update_addr_Winb_n ||
                  !EN_update_addr_Wout_n;

  // Sticky error: enable outside run, or illegal state code; cleared only by reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      addr_err <= 1'b0;
    else if ((any_en && !run) || (SRAM_State == ST_ILL))
      addr_err <= 1'b1;
  end
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_esn_sram_addr_gen.sv
// Bench for esn_sram_addr_gen at NODE_NUM=4, POINT_NUM=3.
module tb_esn_sram_addr_gen;

  localparam int NN = 4;
  localparam int PN = 3;
  localparam int OW = 17;

  logic       clk;
  logic       nrst;
  logic [1:0] sram_state;
  logic [4:0] en_n;  // [4]=X [3]=W [2]=Win [1]=Winb [0]=Wout
  logic [1:0] addr_x;
  logic [3:0] addr_w;
  logic [1:0] addr_win;
  logic [1:0] addr_winb;
  logic [1:0] addr_wout;
  logic [1:0] addr_u;
  logic       x_wrap;
  logic       seq_done;
  logic       addr_err;

  esn_sram_addr_gen #(
    .NODE_NUM(NN), .POINT_NUM(PN), .AW_N(2), .AW_W(4), .AW_P(2)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .SRAM_State(sram_state),
    .EN_update_addr_X_n(en_n[4]),
    .EN_update_addr_W_n(en_n[3]),
    .EN_update_addr_Win_n(en_n[2]),
    .EN_update_addr_Winb_n(en_n[1]),
    .EN_update_addr_Wout_n(en_n[0]),
    .addr_X(addr_x),
    .addr_W(addr_w),
    .addr_Win(addr_win),
    .addr_Winb(addr_winb),
    .addr_Wout(addr_wout),
    .addr_u(addr_u),
    .x_wrap(x_wrap),
    .seq_done(seq_done),
    .addr_err(addr_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [OW-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Behavioural reference: linear counters, W tracked as a flat count mod NN*NN.
  int m_x, m_wcnt, m_win, m_winb, m_wout, m_u;
  bit m_wrap, m_done, m_err;

  function automatic logic [OW-1:0] dut_out();
    return {addr_x, addr_w, addr_win, addr_winb, addr_wout, addr_u, x_wrap, seq_done, addr_err};
  endfunction

  function automatic logic [OW-1:0] model_out();
    return {2'(m_x), 4'(m_wcnt), 2'(m_win), 2'(m_winb), 2'(m_wout), 2'(m_u), m_wrap, m_done, m_err};
  endfunction

  task automatic model_reset();
    m_x = 0; m_wcnt = 0; m_win = 0; m_winb = 0; m_wout = 0; m_u = 0;
    m_wrap = 0; m_done = 0; m_err = 0;
  endtask

  // Driver: apply one cycle of inputs, predict, push expectation, wait past the edge.
  task automatic drive_cycle(input logic [1:0] st, input logic [4:0] en);
    @(negedge clk);
    sram_state = st;
    en_n = en;
`ifdef ESN_ADDR_GEN_ERR_EN
    if (((en != 5'h1f) && (st != 2'b10)) || (st == 2'b11)) m_err = 1;
`endif
    m_wrap = 0;
    m_done = 0;
    if (st != 2'b10) begin
      m_x = 0; m_wcnt = 0; m_win = 0; m_winb = 0; m_wout = 0; m_u = 0;
    end else begin
      if (!en[4]) begin
        m_x = m_x + 1;
        if (m_x == NN) begin
          m_x = 0;
          m_wrap = 1;
          m_u = m_u + 1;
          if (m_u == PN) begin
            m_u = 0;
            m_done = 1;
          end
        end
      end
      if (!en[3]) m_wcnt = (m_wcnt + 1) % (NN * NN);
      if (!en[2]) m_win  = (m_win + 1) % NN;
      if (!en[1]) m_winb = (m_winb + 1) % NN;
      if (!en[0]) m_wout = (m_wout + 1) % NN;
    end
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [OW-1:0] got, exp;
    nrst = 1'b0;
    sram_state = 2'b00;
    en_n = 5'h1f;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    got = dut_out();
    if (got !== '0) $display("FAIL reset_values got=%h exp=%h", got, 17'h0);
    else pass_cnt++;
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(2'b00, (i % 2 == 0) ? 5'h00 : 5'h1f);
      got = dut_out();
      exp = exp_q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL idle_hold cyc=%0d got=%h exp=%h", i, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_x_advance();
    logic [OW-1:0] got, exp;
    logic [1:0] x_tab [5];
    logic       w_tab [5];
    x_tab = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    w_tab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    drive_cycle(2'b00, 5'h1f);
    void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive_cycle(2'b10, 5'b01111);
      got = dut_out();
      exp = exp_q.pop_front();
      chk_cnt++;
      if (got !== exp || addr_x !== x_tab[i] || x_wrap !== w_tab[i])
        $display("FAIL x_advance cyc=%0d got=%h exp=%h addr_x=%0d/%0d x_wrap=%0b/%0b",
                 i, got, exp, addr_x, x_tab[i], x_wrap, w_tab[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (addr_u !== 2'd1) $display("FAIL x_addr_u got=%0d exp=1", addr_u);
    else pass_cnt++;
  endtask

  task automatic test_w_walk();
    logic [OW-1:0] got, exp;
    logic [3:0] w_exp;
    drive_cycle(2'b00, 5'h1f);
    void'(exp_q.pop_front());
    for (int i = 0; i < 17; i++) begin
      drive_cycle(2'b10, 5'b10111);
      w_exp = 4'((i + 1) % 16);
      got = dut_out();
      exp = exp_q.pop_front();
      chk_cnt++;
      if (got !== exp || addr_w !== w_exp)
        $display("FAIL w_walk cyc=%0d got=%h exp=%h addr_w=%0d/%0d", i, got, exp, addr_w, w_exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_seq_done();
    logic [OW-1:0] got, exp;
    int wraps, dones;
    wraps = 0;
    dones = 0;
    drive_cycle(2'b00, 5'h1f);
    void'(exp_q.pop_front());
    for (int i = 0; i < 12; i++) begin
      drive_cycle(2'b10, 5'b01111);
      if (x_wrap === 1'b1) wraps++;
      if (seq_done === 1'b1) begin
        dones++;
        chk_cnt++;
        if (wraps != 3 || x_wrap !== 1'b1) $display("FAIL seq_done_align wraps=%0d exp=3", wraps);
        else pass_cnt++;
      end
      got = dut_out();
      exp = exp_q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL seq_run cyc=%0d got=%h exp=%h", i, got, exp);
      else pass_cnt++;
    end
    chk_cnt++;
    if (dones != 1 || addr_u !== 2'd0) $display("FAIL seq_done_count got=%0d exp=1 addr_u=%0d", dones, addr_u);
    else pass_cnt++;
  endtask

  task automatic test_mid_run_clear();
    logic [OW-1:0] got, exp;
    logic [1:0]  st_tab [6];
    logic [4:0]  en_tab [6];
    st_tab = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10};
    en_tab = '{5'h1f, 5'b01110, 5'b01110, 5'b11110, 5'b01111, 5'b01111};
    for (int i = 0; i < 6; i++) begin
      drive_cycle(st_tab[i], en_tab[i]);
      got = dut_out();
      exp = exp_q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL mid_run_clear step=%0d got=%h exp=%h", i, got, exp);
      else pass_cnt++;
      if (i == 3) begin
        chk_cnt++;
        if (addr_x !== 2'd2 || addr_wout !== 2'd3)
          $display("FAIL mid_run_setup addr_x=%0d exp=2 addr_wout=%0d exp=3", addr_x, addr_wout);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_err_flag();
    logic [OW-1:0] got, exp;
    logic [1:0]  st_tab [5];
    logic [4:0]  en_tab [5];
    st_tab = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b10};
    en_tab = '{5'b11011, 5'h1f, 5'b11011, 5'h1f, 5'h1f};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(st_tab[i], en_tab[i]);
      got = dut_out();
      exp = exp_q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL err_flag step=%0d got=%h exp=%h", i, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_random_back_to_back();
    logic [OW-1:0] got, exp;
    logic [1:0] st;
    for (int i = 0; i < 300; i++) begin
      st = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      drive_cycle(st, 5'($urandom_range(0, 31)));
      got = dut_out();
      exp = exp_q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL random cyc=%0d got=%h exp=%h", i, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    logic [OW-1:0] got;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(2'b10, 5'h00);
      void'(exp_q.pop_front());
    end
    #2;
    nrst = 1'b0;
    #1;
    got = dut_out();
    chk_cnt++;
    if (got !== '0) $display("FAIL async_reset got=%h exp=%h", got, 17'h0);
    else pass_cnt++;
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_x_advance();
    test_w_walk();
    test_seq_done();
    test_mid_run_clear();
    test_err_flag();
    test_random_back_to_back();
    test_async_reset();
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
